// File: rtl/vrf_pkg.sv
// vrf_pkg: shared constants and types for the vector register file write-back path.
package vrf_pkg;
    localparam int NREGS = 10;
    localparam int IDXW  = 4;
    localparam int LANES = 6;
    localparam int LANEW = 8;
    typedef logic [LANES-1:0][LANEW-1:0] vec_t;
    typedef logic [IDXW-1:0] ridx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; first set req bit at or after ptr (wrapping).
// Ports: req (request vector), ptr (search start), gnt (one-hot grant), gidx (encoded grant).
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW = NREQ > 1 ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gidx
);
    logic found;
    always_comb begin
        gnt = '0;
        gidx = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (int'(ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found = 1'b1;
                gnt[k] = 1'b1;
                gidx = PW'(k);
            end
        end
    end
endmodule

// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: round-robin write-back arbiter, registered RF write port and busy scoreboard.
// Ports: clk/rst_n (async active-low); req_valid/req_idx/req_data/req_ready (per-requester
// handshake, flattened); we3/a3/wd3 (registered RF write); sb_mark/sb_mark_idx/flush/busy
// (scoreboard); err_idx (sticky out-of-range index). Optional VRF_WB_PERF_EN adds
// perf_writes/perf_stalls saturating counters.
module vrf_wb_arbiter #(
    parameter int NREQ  = 2,
    parameter int NREGS = vrf_pkg::NREGS,
    parameter int IDXW  = vrf_pkg::IDXW,
    parameter int LANES = vrf_pkg::LANES,
    parameter int LANEW = vrf_pkg::LANEW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*IDXW-1:0]          req_idx,
    input  logic [NREQ*LANES*LANEW-1:0]   req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          we3,
    output logic [IDXW-1:0]               a3,
    output logic [LANES*LANEW-1:0]        wd3,
    input  logic                          sb_mark,
    input  logic [IDXW-1:0]               sb_mark_idx,
    output logic [NREGS-1:0]              busy,
    input  logic                          flush,
    output logic                          err_idx
`ifdef VRF_WB_PERF_EN
    ,
    output logic [15:0]                   perf_writes,
    output logic [15:0]                   perf_stalls
`endif
);
    import vrf_pkg::*;
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int DW = LANES * LANEW;
    logic [PW-1:0]    rr_q, rr_d, gidx;
    logic [NREQ-1:0]  gnt;
    logic             we3_q, we3_d, err_q, err_d, hs, ok;
    logic [IDXW-1:0]  a3_q, a3_d, idx_g;
    logic [DW-1:0]    wd3_q, wd3_d, dat_g;
    logic [NREGS-1:0] busy_q, busy_d, set_v, clr_v;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req  (req_valid),
        .ptr  (rr_q),
        .gnt  (gnt),
        .gidx (gidx)
    );

    // No grants while reset is held so nothing is consumed that would be dropped.
    assign req_ready = rst_n ? gnt : '0;

    always_comb begin
        idx_g = '0;
        dat_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                idx_g = req_idx[i*IDXW +: IDXW];
                dat_g = req_data[i*DW +: DW];
            end
        end
        hs = |req_ready;
        ok = int'(idx_g) < NREGS;
        rr_d = !hs ? rr_q : (int'(gidx) == NREQ - 1 ? '0 : gidx + 1'b1);
        // Out-of-range requests are consumed but never reach the register file.
        we3_d = hs && ok;
        a3_d = we3_d ? idx_g : a3_q;
        wd3_d = we3_d ? dat_g : wd3_q;
        set_v = (sb_mark && int'(sb_mark_idx) < NREGS) ? NREGS'(1) << sb_mark_idx : '0;
        clr_v = we3_d ? NREGS'(1) << idx_g : '0;
        // Set is OR-ed after clear so a fresh mark survives a same-cycle retire.
        busy_d = flush ? '0 : (busy_q & ~clr_v) | set_v;
        err_d = err_q | (hs && !ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign we3     = we3_q;
    assign a3      = a3_q;
    assign wd3     = wd3_q;
    assign busy    = busy_q;
    assign err_idx = err_q;

`ifdef VRF_WB_PERF_EN
    logic [15:0] perf_writes_q, perf_writes_d, perf_stalls_q, perf_stalls_d;
    always_comb begin
        perf_writes_d = (we3_q && perf_writes_q != 16'hFFFF) ? perf_writes_q + 16'd1 : perf_writes_q;
        perf_stalls_d = (|(req_valid & ~req_ready) && perf_stalls_q != 16'hFFFF) ? perf_stalls_q + 16'd1 : perf_stalls_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_writes_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_writes_q <= perf_writes_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end
    assign perf_writes = perf_writes_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule
